// File: rtl/k_fetch_unit.sv
// Instruction fetch unit: 10-bit PC driving a combinational instruction memory and a DEPTH-entry prefetch FIFO.
// Optional macro K_FETCH_STALL_CNT_EN adds a saturating stall_cnt output.
module k_fetch_unit #(
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef K_FETCH_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [9:0] RESET_PC_W = 10'(RESET_PC);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [9:0]       pc_q, pc_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      buf_instr_q [DEPTH];
    logic [31:0]      buf_instr_d [DEPTH];
    logic [9:0]       buf_pc_q    [DEPTH];
    logic [9:0]       buf_pc_d    [DEPTH];

    logic push;
    logic pop;
    logic unused_redirect_hi;

    assign unused_redirect_hi = ^redirect_pc[31:10];

    assign imem_addr = {22'b0, pc_q};
    assign out_valid = (count_q != '0);
    assign out_instr = out_valid ? buf_instr_q[head_q] : 32'b0;
    assign out_pc    = out_valid ? {22'b0, buf_pc_q[head_q]} : 32'b0;

    // A pop during redirect is still computed but the redirect branch below overrides it.
    assign pop  = out_valid && out_ready;
    assign push = fetch_en && !redirect && ((count_q < FULL_CNT) || pop);

    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect) begin
            pc_d    = redirect_pc[9:0];
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
                pc_d   = pc_q + 10'd1;
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        if (push) begin
            buf_instr_d[tail_q] = imem_instr;
            buf_pc_d[tail_q]    = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC_W;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; outputs are masked while the buffer is empty.
    always_ff @(posedge clk) begin
        buf_instr_q <= buf_instr_d;
        buf_pc_q    <= buf_pc_d;
    end

`ifdef K_FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (redirect) begin
            stall_cnt_d = 32'b0;
        end else if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_k_fetch_unit.sv
// Bench for k_fetch_unit: directed vector table, async-reset sequence and randomized run against a queue model.
module tb_k_fetch_unit;

    localparam int DEPTH    = 4;
    localparam int RESET_PC = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef K_FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    logic [31:0] tb_mem [1024];

    int tests = 0;
    int fails = 0;

    int unsigned mq[$];
    int unsigned mpc;
    logic [31:0] mstall;

    typedef struct {
        bit          rst;
        bit          fe;
        bit          rdy;
        bit          redir;
        logic [31:0] rpc;
        bit          ev;
        int unsigned epc;
        int unsigned eaddr;
        int          estall;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    assign imem_instr = tb_mem[imem_addr[9:0]];

    k_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_en   (fetch_en),
        .imem_addr  (imem_addr),
        .imem_instr (imem_instr),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc)
`ifdef K_FETCH_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpc    = RESET_PC % 1024;
        mstall = 32'b0;
    endtask

    // Queue model: evaluated on the inputs and state present just before the edge.
    task automatic model_step();
        bit pop;
        bit push;
        pop = (mq.size() != 0) && out_ready;
        if (redirect) begin
            mq.delete();
            mpc    = redirect_pc % 1024;
            mstall = 32'b0;
        end else begin
            if ((mq.size() != 0) && !out_ready && (mstall != 32'hFFFF_FFFF)) mstall = mstall + 32'd1;
            push = fetch_en && ((mq.size() < DEPTH) || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(mpc);
                mpc = (mpc + 1) % 1024;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        bit ev;
        ev = (mq.size() != 0);
        chk({tag, "_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, "_pc"}, out_pc, ev ? 32'(mq[0]) : 32'b0);
        chk({tag, "_instr"}, out_instr, ev ? tb_mem[mq[0]] : 32'b0);
        chk({tag, "_addr"}, imem_addr, 32'(mpc));
`ifdef K_FETCH_STALL_CNT_EN
        chk({tag, "_stall"}, stall_cnt, mstall);
`endif
    endtask

    // Asserts reset between clock edges and checks the outputs before any edge occurs.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_valid", 32'(out_valid), 32'b0);
        chk("rst_pc", out_pc, 32'b0);
        chk("rst_instr", out_instr, 32'b0);
        chk("rst_addr", imem_addr, 32'(RESET_PC));
`ifdef K_FETCH_STALL_CNT_EN
        chk("rst_stall", stall_cnt, 32'b0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add(input bit rst, input bit fe, input bit rdy, input bit redir, input logic [31:0] rpc,
                       input bit ev, input int unsigned epc, input int unsigned eaddr, input int estall);
        vec_t v;
        v.rst = rst; v.fe = fe; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.estall = estall;
        tbl.push_back(v);
    endtask

    initial begin
        vec_t v;
        for (int i = 0; i < 1024; i++) tb_mem[i] = $urandom;
        tb_mem[0] = 32'd1;
        tb_mem[1] = 32'd2;
        tb_mem[2] = 32'd3;
        tb_mem[3] = 32'd0;

        // Streaming after reset: no bubbles
        add(1, 1, 1, 0, 0, 1, 0, 1, -1);
        add(0, 1, 1, 0, 0, 1, 1, 2, -1);
        add(0, 1, 1, 0, 0, 1, 2, 3, -1);
        add(0, 1, 1, 0, 0, 1, 3, 4, -1);
        // Back-pressure fills the buffer; pc stops at 4
        add(1, 1, 0, 0, 0, 1, 0, 1, 0);
        add(0, 1, 0, 0, 0, 1, 0, 2, -1);
        add(0, 1, 0, 0, 0, 1, 0, 3, -1);
        add(0, 1, 0, 0, 0, 1, 0, 4, -1);
        for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, 1, 0, 4, -1);
        add(0, 1, 0, 0, 0, 1, 0, 4, 9);
        // Full buffer with push and pop on the same edge
        add(0, 1, 1, 0, 0, 1, 1, 5, 9);
        add(0, 1, 1, 0, 0, 1, 2, 6, -1);
        add(0, 1, 1, 0, 0, 1, 3, 7, -1);
        // Drain one, then redirect with three entries buffered
        add(0, 0, 1, 0, 0, 1, 4, 7, -1);
        add(0, 1, 1, 1, 32'h1234_FE00, 0, 0, 32'h200, 0);
        add(0, 1, 1, 0, 0, 1, 32'h200, 32'h201, -1);
        add(0, 1, 1, 0, 0, 1, 32'h201, 32'h202, -1);
        // PC wrap from 1023 to 0, then fetch_en low freezes pc
        add(0, 1, 1, 1, 32'd1022, 0, 0, 1022, -1);
        add(0, 1, 1, 0, 0, 1, 1022, 1023, -1);
        add(0, 1, 1, 0, 0, 1, 1023, 0, -1);
        add(0, 1, 1, 0, 0, 1, 0, 1, -1);
        add(0, 0, 1, 0, 0, 0, 0, 1, -1);
        add(0, 0, 0, 0, 0, 0, 0, 1, -1);

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            if (v.rst) do_reset();
            fetch_en    = v.fe;
            out_ready   = v.rdy;
            redirect    = v.redir;
            redirect_pc = v.rpc;
            tick();
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(v.ev));
            chk($sformatf("tbl%0d_pc", i), out_pc, v.ev ? 32'(v.epc) : 32'b0);
            chk($sformatf("tbl%0d_instr", i), out_instr, v.ev ? tb_mem[v.epc % 1024] : 32'b0);
            chk($sformatf("tbl%0d_addr", i), imem_addr, 32'(v.eaddr));
`ifdef K_FETCH_STALL_CNT_EN
            if (v.estall >= 0) chk($sformatf("tbl%0d_stall", i), stall_cnt, 32'(v.estall));
`endif
        end
        redirect = 1'b0;

        // Asynchronous reset in the middle of a stream
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_model("pre_rst");
        end
        do_reset();
        out_ready = 1'b1;
        tick();
        chk("post_rst_valid", 32'(out_valid), 32'b1);
        chk("post_rst_pc", out_pc, 32'(RESET_PC));
        check_model("post_rst");

        // Randomized run against the queue model
        for (int i = 0; i < 3000; i++) begin
            fetch_en    = ($urandom_range(0, 9) < 8);
            out_ready   = ($urandom_range(0, 9) < 6);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom;
            tick();
            check_model("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
